seq_priority_encoder: RTL and testbench
=======================================

// Module: seq_priority_encoder
// PURPOSE
//  Parametrised N-to-log2(N) encoder with sequential drain. Accepts a request
//  vector (any number of bits set), then emits the index of every set bit, one
//  per handshake, on a valid/ready output stream. Fixed (lowest index first) or
//  round-robin order. Generalises our one-hot 4-to-2 encoder to multi-hot input.
// PARAMETERS
//  N     8   request vector width; >= 2, power of two not required
//  MODE  0   0 = fixed priority (lowest set index first), 1 = round-robin
//  W     $clog2(N)   localparam, index width (not overridable)
// PORTS
//  clk         in   1    single clock, all state on rising edge
//  rst         in   1    synchronous reset, active-high
//  req_i       in   N    request vector
//  req_valid   in   1    req_i valid
//  req_ready   out  1    block can accept a vector (state IDLE)
//  idx_o       out  W    index of bit being served
//  idx_valid   out  1    idx_o valid
//  idx_ready   in   1    downstream accepts idx_o
//  idx_last    out  1    idx_o is the final set bit of the current vector
//  pend_cnt_o  out  W+1  set bits still pending (incl. the one on idx_o)
//  zero_o      out  1    one-cycle pulse: all-zero vector accepted, discarded
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE, pending=0, rr_ptr=0, zero_o=0.
//    Outputs then: req_ready=1, idx_valid=0, idx_o=0, idx_last=0, pend_cnt_o=0.
//    Reset mid-drain discards pending bits; no further idx_valid.
//  - States: IDLE (req_ready=1), DRAIN (idx_valid=1). req_ready=0 in DRAIN.
//  - IDLE, req_valid=1: vector registered. Nonzero -> DRAIN next cycle,
//    first idx_valid one cycle after acceptance. Zero -> stay IDLE, zero_o=1
//    next cycle for exactly one cycle.
//  - DRAIN: idx_o/idx_valid/idx_last/pend_cnt_o are functions of registers
//    only (no comb path from req_* or idx_ready). Held stable while
//    idx_ready=0. On idx_valid&&idx_ready: served bit cleared, pend_cnt_o-1;
//    if idx_last, -> IDLE (req_ready=1 the next cycle).
//  - Throughput: k set bits -> k output beats + 1 IDLE cycle before next
//    vector is accepted (no accept during final beat).
//  - MODE=0: select lowest set pending index. rr_ptr unused, stays 0.
//  - MODE=1: select lowest set index >= rr_ptr; if none, lowest set index
//    overall (wrap). On each handshake rr_ptr <= (idx_o+1) mod N, wrapping
//    N-1 -> 0. rr_ptr persists across vectors; cleared only by rst.
//  - idx_last = exactly one pending bit. pend_cnt_o = popcount(pending).
//  - req_i bits change while not accepted: ignored. Non-power-of-two N:
//    indices N..2^W-1 never produced.
// STRUCTURE
//  - Package enc_pkg: state enum {IDLE, DRAIN}; MODE_FIXED=0, MODE_RR=1.
//  - Sub-module prio_pick #(N): comb, vector -> {found, lowest index}.
//    Two instances in RR mode (masked by rr_ptr, unmasked), one in fixed.
//  - Top: FSM, pending reg, rr_ptr reg, popcount, output logic.
// TESTING (N=8)
//  1 MODE=0, req_i=8'b1010_0100, idx_ready=1 -> idx_o 2,5,7 on consecutive
//    cycles, pend_cnt 3,2,1, idx_last only on 7, req_ready=1 the cycle after.
//  2 MODE=0, same vector, idx_ready=0 for 3 cycles at first beat -> idx_o=2,
//    idx_valid=1, pend_cnt=3 held stable all 3 cycles, then 2,5,7.
//  3 MODE=1, 8'b0001_0001 -> 0,4 (rr_ptr=5); then 8'b0010_1001 -> 5,0,3.
//  4 req_i=8'h00 accepted -> zero_o=1 one cycle, idx_valid stays 0,
//    req_ready stays 1.
//  5 MODE=1, 8'hFF, rst=1 after first beat -> next cycle idx_valid=0,
//    req_ready=1, pend_cnt=0; then 8'h02 -> idx 1 (rr_ptr back at 0).
//  6 One-hot sweep 8'h01..8'h80 -> idx_o 0..7, each single beat, idx_last=1.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and constants for the sequential priority encoder.
// FSM state encoding and the MODE parameter values.
package enc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/prio_pick.sv
// Combinational lowest-set-bit finder: returns whether any bit is set and the
// index of the lowest one.
module prio_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      found = found | vec[i];
      idx   = vec[i] ? W'(i) : idx;
    end
  end

endmodule

// File: rtl/seq_priority_encoder.sv
// Multi-hot request vector in, one index per valid/ready beat out, in fixed
// (lowest first) or round-robin order.
module seq_priority_encoder
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = 0,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] idx_o,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic         idx_last,
  output logic [W:0]   pend_cnt_o,
  output logic         zero_o
);

  state_e       state_r, state_next_s;
  logic [N-1:0] pending_r, pending_next_s;
  logic [W-1:0] rr_ptr_r, rr_next_s;
  logic         zero_r, zero_next_s;

  logic         found_s;
  logic [W-1:0] sel_s;
  logic [W:0]   cnt_s;
  logic         fire_s;
  logic         last_s;
  logic [N-1:0] serve_mask_s;

  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  if (MODE == MODE_RR) begin : g_rr
    logic [N-1:0] mask_s;
    logic [N-1:0] masked_s;
    logic         found_m_s;
    logic [W-1:0] idx_m_s;
    logic [W-1:0] idx_u_s;

    // Keep only pending bits at or above the round-robin pointer.
    always_comb begin
      mask_s = '0;
      for (int i = 0; i < N; i++) begin
        mask_s[i] = (i >= int'(rr_ptr_r));
      end
    end

    assign masked_s = pending_r & mask_s;

    prio_pick #(.N(N)) u_pick_masked (
      .vec   (masked_s),
      .found (found_m_s),
      .idx   (idx_m_s)
    );

    prio_pick #(.N(N)) u_pick_all (
      .vec   (pending_r),
      .found (found_s),
      .idx   (idx_u_s)
    );

    // Nothing at or above the pointer means wrap to the lowest index overall.
    assign sel_s = found_m_s ? idx_m_s : idx_u_s;
  end else begin : g_fixed
    prio_pick #(.N(N)) u_pick_all (
      .vec   (pending_r),
      .found (found_s),
      .idx   (sel_s)
    );
  end

  assign cnt_s        = popcount(pending_r);
  assign last_s       = (cnt_s == (W + 1)'(1));
  assign fire_s       = (state_r == DRAIN) && found_s && idx_ready;
  assign serve_mask_s = {{(N - 1){1'b0}}, 1'b1} << sel_s;

  // Next-state, pending vector, pointer and zero-pulse logic.
  always_comb begin
    state_next_s   = state_r;
    pending_next_s = pending_r;
    rr_next_s      = rr_ptr_r;
    zero_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          pending_next_s = req_i;
          if (req_i != '0) begin
            state_next_s = DRAIN;
          end else begin
            zero_next_s = 1'b1;
          end
        end else begin
          pending_next_s = pending_r;
        end
      end
      DRAIN: begin
        if (fire_s) begin
          pending_next_s = pending_r & ~serve_mask_s;
          if (MODE == MODE_RR) begin
            rr_next_s = (sel_s == W'(N - 1)) ? '0 : sel_s + W'(1);
          end else begin
            rr_next_s = rr_ptr_r;
          end
          if (last_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DRAIN;
          end
        end else begin
          pending_next_s = pending_r;
        end
      end
      default: begin
        state_next_s   = IDLE;
        pending_next_s = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= '0;
      rr_ptr_r  <= '0;
      zero_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= pending_next_s;
      rr_ptr_r  <= rr_next_s;
      zero_r    <= zero_next_s;
    end
  end

  // Outputs depend only on registered state, so they hold while stalled.
  assign req_ready  = (state_r == IDLE);
  assign idx_valid  = (state_r == DRAIN);
  assign idx_o      = idx_valid ? sel_s : '0;
  assign idx_last   = idx_valid && last_s;
  assign pend_cnt_o = cnt_s;
  assign zero_o     = zero_r;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: one fixed-priority and one round-robin
// instance, directed table vectors, a reset-mid-drain sequence, random traffic.
module tb_seq_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_i      [2];
  logic         req_valid  [2];
  logic         req_ready  [2];
  logic [W-1:0] idx_o      [2];
  logic         idx_valid  [2];
  logic         idx_ready  [2];
  logic         idx_last   [2];
  logic [W:0]   pend_cnt_o [2];
  logic         zero_o     [2];

  int checks    = 0;
  int failures  = 0;
  int model_ptr = 0;
  int exp_q[$];

  typedef struct {
    int         m;
    logic [7:0] v;
    int         stall;
    int         n;
    int         exp [8];
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_priority_encoder #(.N(N), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req_i[0]), .req_valid(req_valid[0]),
    .req_ready(req_ready[0]), .idx_o(idx_o[0]), .idx_valid(idx_valid[0]),
    .idx_ready(idx_ready[0]), .idx_last(idx_last[0]),
    .pend_cnt_o(pend_cnt_o[0]), .zero_o(zero_o[0])
  );

  seq_priority_encoder #(.N(N), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req_i[1]), .req_valid(req_valid[1]),
    .req_ready(req_ready[1]), .idx_o(idx_o[1]), .idx_valid(idx_valid[1]),
    .idx_ready(idx_ready[1]), .idx_last(idx_last[1]),
    .pend_cnt_o(pend_cnt_o[1]), .zero_o(zero_o[1])
  );

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, m, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int m);
    chk("idle_req_ready", m, 32'(req_ready[m]), 32'd1);
    chk("idle_idx_valid", m, 32'(idx_valid[m]), 32'd0);
    chk("idle_idx_o", m, 32'(idx_o[m]), 32'd0);
    chk("idle_idx_last", m, 32'(idx_last[m]), 32'd0);
    chk("idle_pend_cnt", m, 32'(pend_cnt_o[m]), 32'd0);
  endtask

  // Reference order: fixed mode emits ascending indices; round-robin emits
  // set bits in cyclic order starting at the pointer.
  task automatic model_order(input int m, input logic [7:0] v);
    int start;
    exp_q.delete();
    start = (m == 1) ? model_ptr : 0;
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) exp_q.push_back((start + k) % N);
    end
  endtask

  task automatic drain(input int m, input logic [7:0] v, input int stall_first, input bit rand_stall);
    int n;
    int stall;
    chk("ready_before_accept", m, 32'(req_ready[m]), 32'd1);
    req_i[m]     = v;
    req_valid[m] = 1'b1;
    tick();
    req_valid[m] = 1'b0;
    req_i[m]     = 8'($urandom);
    n = exp_q.size();
    if (n == 0) begin
      chk("zero_pulse", m, 32'(zero_o[m]), 32'd1);
      chk("zero_idx_valid", m, 32'(idx_valid[m]), 32'd0);
      chk("zero_req_ready", m, 32'(req_ready[m]), 32'd1);
      tick();
      chk("zero_pulse_end", m, 32'(zero_o[m]), 32'd0);
      chk("zero_idx_valid2", m, 32'(idx_valid[m]), 32'd0);
    end else begin
      for (int j = 0; j < n; j++) begin
        stall = (j == 0) ? stall_first : (rand_stall ? int'($urandom_range(0, 2)) : 0);
        for (int s = 0; s <= stall; s++) begin
          idx_ready[m] = (s == stall);
          req_valid[m] = 1'($urandom);
          req_i[m]     = 8'($urandom);
          chk("beat_valid", m, 32'(idx_valid[m]), 32'd1);
          chk("beat_idx", m, 32'(idx_o[m]), 32'(exp_q[j]));
          chk("beat_pend_cnt", m, 32'(pend_cnt_o[m]), 32'(n - j));
          chk("beat_last", m, 32'(idx_last[m]), 32'(j == n - 1));
          chk("beat_req_ready", m, 32'(req_ready[m]), 32'd0);
          chk("beat_zero", m, 32'(zero_o[m]), 32'd0);
          tick();
        end
      end
      req_valid[m] = 1'b0;
      idx_ready[m] = 1'b0;
      check_idle(m);
      if (m == 1) model_ptr = (exp_q[n - 1] + 1) % N;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      req_i[m]     = '0;
      req_valid[m] = 1'b0;
      idx_ready[m] = 1'b0;
    end

    tbl.push_back('{0, 8'hA4, 0, 3, '{2, 5, 7, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 8'hA4, 3, 3, '{2, 5, 7, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 8'h11, 0, 2, '{0, 4, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 8'h29, 0, 3, '{5, 0, 3, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 8'h00, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 8'h00, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}});
    for (int i = 0; i < N; i++) begin
      tbl.push_back('{0, 8'(1 << i), 0, 1, '{i, 0, 0, 0, 0, 0, 0, 0}});
    end

    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      check_idle(m);
      chk("reset_zero", m, 32'(zero_o[m]), 32'd0);
    end
    rst = 1'b0;
    tick();

    foreach (tbl[t]) begin
      exp_q.delete();
      for (int k = 0; k < tbl[t].n; k++) exp_q.push_back(tbl[t].exp[k]);
      drain(tbl[t].m, tbl[t].v, tbl[t].stall, 1'b0);
    end

    // Reset in the middle of a round-robin drain of 8'hFF.
    model_order(1, 8'hFF);
    req_i[1]     = 8'hFF;
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    chk("rst_first_idx", 1, 32'(idx_o[1]), 32'(exp_q[0]));
    chk("rst_first_cnt", 1, 32'(pend_cnt_o[1]), 32'd8);
    idx_ready[1] = 1'b1;
    tick();
    idx_ready[1] = 1'b0;
    chk("rst_second_valid", 1, 32'(idx_valid[1]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    check_idle(1);
    check_idle(0);
    tick();
    check_idle(1);
    // A stale pointer past bit 1 would serve bit 5 first.
    model_order(1, 8'h22);
    chk("rst_ptr_order", 1, 32'(exp_q[0]), 32'd1);
    drain(1, 8'h22, 0, 1'b0);

    for (int r = 0; r < 80; r++) begin
      int          m;
      logic [7:0]  v;
      m = int'($urandom_range(0, 1));
      v = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      model_order(m, v);
      drain(m, v, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
